// File: rtl/ntt_cmd_scheduler_pkg.sv
// Shared types for the NTT command scheduler: opcodes, slot limit, FSM states, command struct.
// No logic here; consumed by the interface, the FIFO wrapper and the scheduler top.
// The command tag width is fixed here; the scheduler's TAG_W parameter defaults to it.
package ntt_pkg;

  localparam logic [7:0] OPC_LOAD  = 8'h02;
  localparam logic [7:0] OPC_STORE = 8'h03;
  localparam logic [7:0] OPC_NTT   = 8'h10;
  localparam logic [7:0] OPC_INTT  = 8'h11;

  localparam int NUM_SLOTS = 4;
  localparam int CMD_TAG_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_REJECT
  } state_t;

  typedef struct packed {
    logic [7:0]           opcode;
    logic [3:0]           slot;
    logic [47:0]          dma_addr;
    logic [CMD_TAG_W-1:0] tag;
  } cmd_t;

  // A command is executable only with a known opcode and an existing slot.
  function automatic logic is_legal(input cmd_t c);
    logic op_ok;
    op_ok = (c.opcode == OPC_LOAD) || (c.opcode == OPC_STORE) ||
            (c.opcode == OPC_NTT)  || (c.opcode == OPC_INTT);
    return op_ok && (c.slot < 4'(NUM_SLOTS));
  endfunction

endpackage

// File: rtl/ntt_cmd_scheduler_if.sv
// Host, engine and completion signals of the NTT command scheduler bundled as one interface.
// Latency: none, pure wiring.
// Backpressure: host side is valid/ready; engine side is an issue pulse plus a ready level.
interface ntt_cmd_scheduler_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = ntt_pkg::CMD_TAG_W
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             host_valid;
  logic             host_ready;
  logic [7:0]       host_opcode;
  logic [3:0]       host_slot;
  logic [47:0]      host_dma_addr;
  logic [TAG_W-1:0] host_tag;

  logic             eng_cmd_valid;
  logic [7:0]       eng_cmd_opcode;
  logic [3:0]       eng_cmd_slot;
  logic [47:0]      eng_cmd_dma_addr;
  logic             eng_ready;

  logic             done_valid;
  logic [TAG_W-1:0] done_tag;
  logic             done_err;

  logic [CW-1:0]    fifo_count;
  logic             idle;

  // Host and engine model side.
  modport master (
    output host_valid, host_opcode, host_slot, host_dma_addr, host_tag, eng_ready,
    input  host_ready, eng_cmd_valid, eng_cmd_opcode, eng_cmd_slot, eng_cmd_dma_addr,
    input  done_valid, done_tag, done_err, fifo_count, idle
  );

  // Scheduler side.
  modport slave (
    input  host_valid, host_opcode, host_slot, host_dma_addr, host_tag, eng_ready,
    output host_ready, eng_cmd_valid, eng_cmd_opcode, eng_cmd_slot, eng_cmd_dma_addr,
    output done_valid, done_tag, done_err, fifo_count, idle
  );

endinterface

// File: rtl/ntt_cmd_scheduler_fifo.sv
// Generic synchronous FIFO holding queued commands; head is the oldest entry.
// Latency: a push is visible at the head one cycle later; pop is registered.
// Backpressure: push ignored when full, pop ignored when empty; caller uses full/empty.
module ntt_cmd_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ntt_cmd_scheduler.sv
// Queues host NTT commands, issues legal ones to the engine one at a time, rejects the rest locally.
// Latency: push t -> issue pulse t+2; done one cycle after engine ready returns; reject done at pop+1.
// Backpressure: host_ready drops at full (no bypass); optional NTT_SCHED_PERF_EN adds perf counters.
module ntt_cmd_scheduler
  import ntt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = CMD_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  ntt_cmd_scheduler_if.slave bus
`ifdef NTT_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_cmds,
  output logic [31:0]        perf_busy
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  cmd_t             push_cmd;
  cmd_t             head;
  cmd_t             cur;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             pop;
  logic             issue_ld;
  logic             rej;
  logic             done_fire;
  state_t           state;
  state_t           state_nxt;
  logic             done_vld_q;
  logic             done_err_q;
  logic [TAG_W-1:0] done_tag_q;

  assign push_cmd = '{opcode:   bus.host_opcode,
                      slot:     bus.host_slot,
                      dma_addr: bus.host_dma_addr,
                      tag:      bus.host_tag};

  ntt_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.host_valid),
    .push_dat (push_cmd),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and pop decisions; no pop while a completion is being reported.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue_ld  = 1'b0;
    rej       = 1'b0;
    done_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !done_vld_q) begin
          if (!is_legal(head)) begin
            pop       = 1'b1;
            rej       = 1'b1;
            state_nxt = S_REJECT;
          end else if (bus.eng_ready) begin
            pop       = 1'b1;
            issue_ld  = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.eng_ready) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.eng_ready) begin
          done_fire = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_REJECT:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Issue registers change only on a legal issue so rejected heads never disturb them.
  always_ff @(posedge clk) begin
    if (rst)           cur <= '0;
    else if (issue_ld) cur <= head;
  end

  // Completion is registered: engine done or local reject both report one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_vld_q <= 1'b0;
      done_err_q <= 1'b0;
      done_tag_q <= '0;
    end else begin
      done_vld_q <= done_fire || rej;
      if (done_fire) begin
        done_err_q <= 1'b0;
        done_tag_q <= cur.tag;
      end else if (rej) begin
        done_err_q <= 1'b1;
        done_tag_q <= head.tag;
      end
    end
  end

  assign bus.host_ready       = !full;
  assign bus.fifo_count       = count;
  assign bus.idle             = empty && (state == S_IDLE);
  assign bus.eng_cmd_valid    = (state == S_ISSUE);
  assign bus.eng_cmd_opcode   = cur.opcode;
  assign bus.eng_cmd_slot     = cur.slot;
  assign bus.eng_cmd_dma_addr = cur.dma_addr;
  assign bus.done_valid       = done_vld_q;
  assign bus.done_err         = done_err_q;
  assign bus.done_tag         = done_tag_q;

`ifdef NTT_SCHED_PERF_EN
  // Successful completions and non-idle cycles; both wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cmds <= '0;
      perf_busy <= '0;
    end else begin
      if (done_vld_q && !done_err_q) perf_cmds <= perf_cmds + 32'd1;
      if (state != S_IDLE)           perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_cmd_scheduler.sv
// Directed bench for ntt_cmd_scheduler with a ready-level engine model and event monitor.
// Expected values are hand-derived cycle offsets, tags and fields.
// Perf counter checks are active when NTT_SCHED_PERF_EN is defined.
module tb_ntt_cmd_scheduler;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ntt_cmd_scheduler_if #(.DEPTH(8), .TAG_W(4)) bus ();

`ifdef NTT_SCHED_PERF_EN
  logic [31:0] perf_cmds;
  logic [31:0] perf_busy;
`endif

  ntt_cmd_scheduler #(.DEPTH(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef NTT_SCHED_PERF_EN
    ,
    .perf_cmds (perf_cmds),
    .perf_busy (perf_busy)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: drops ready for busy_len cycles after each issue pulse.
  int   eng_cnt   = 0;
  int   busy_len  = 10;
  logic eng_hold  = 1'b0;
  logic eng_rdy_m = 1'b1;
  assign bus.eng_ready = eng_rdy_m;

  always @(negedge clk) begin
    if (rst)                    eng_cnt = 0;
    else if (bus.eng_cmd_valid) eng_cnt = busy_len;
    else if (eng_cnt > 0)       eng_cnt = eng_cnt - 1;
    eng_rdy_m = (eng_cnt == 0) && !eng_hold;
  end

  // Event monitor.
  int          iss_cyc[$];
  logic [7:0]  iss_op[$];
  logic [3:0]  iss_slot[$];
  logic [47:0] iss_addr[$];
  int          dn_cyc[$];
  logic [3:0]  dn_tag[$];
  logic        dn_err[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.eng_cmd_valid) begin
        iss_cyc.push_back(cyc);
        iss_op.push_back(bus.eng_cmd_opcode);
        iss_slot.push_back(bus.eng_cmd_slot);
        iss_addr.push_back(bus.eng_cmd_dma_addr);
      end
      if (bus.done_valid) begin
        dn_cyc.push_back(cyc);
        dn_tag.push_back(bus.done_tag);
        dn_err.push_back(bus.done_err);
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    iss_cyc.delete(); iss_op.delete(); iss_slot.delete(); iss_addr.delete();
    dn_cyc.delete();  dn_tag.delete(); dn_err.delete();
  endtask

  // Presents one command for one cycle; reports the cycle and whether it was accepted.
  task automatic push(input logic [7:0] op, input logic [3:0] sl, input logic [47:0] ad,
                      input logic [3:0] tg, output int t, output logic acc);
    bus.host_opcode   = op;
    bus.host_slot     = sl;
    bus.host_dma_addr = ad;
    bus.host_tag      = tg;
    bus.host_valid    = 1'b1;
    t   = cyc;
    acc = bus.host_ready;
    tick(1);
    bus.host_valid = 1'b0;
  endtask

  logic [7:0] opc_tab [4];
  int         t0;
  int         r;
  logic       acc;

  initial begin
    opc_tab = '{OPC_LOAD, OPC_STORE, OPC_NTT, OPC_INTT};
    bus.host_valid    = 1'b0;
    bus.host_opcode   = '0;
    bus.host_slot     = '0;
    bus.host_dma_addr = '0;
    bus.host_tag      = '0;

    // Reset values.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_host_ready", bus.host_ready, 1);
    check("rst_idle", bus.idle, 1);
    check("rst_fifo_count", bus.fifo_count, 0);
    check("rst_eng_cmd_valid", bus.eng_cmd_valid, 0);
    check("rst_done_valid", bus.done_valid, 0);
    check("rst_done_err", bus.done_err, 0);
    check("rst_done_tag", bus.done_tag, 0);
    check("rst_eng_opcode", bus.eng_cmd_opcode, 0);
    check("rst_eng_slot", bus.eng_cmd_slot, 0);
    check("rst_eng_addr", bus.eng_cmd_dma_addr, 0);

    // Single NTT command, engine busy for 10 cycles.
    clear_ev();
    busy_len = 10;
    push(OPC_NTT, 4'd1, 48'h1234_5678_9ABC, 4'd3, t0, acc);
    tick(19);
    check("t1_accept", acc, 1);
    check("t1_issue_count", iss_cyc.size(), 1);
    if (iss_cyc.size() > 0) begin
      check("t1_issue_cycle", iss_cyc[0], t0 + 2);
      check("t1_issue_opcode", iss_op[0], 8'h10);
      check("t1_issue_slot", iss_slot[0], 1);
      check("t1_issue_addr", iss_addr[0], 48'h1234_5678_9ABC);
    end
    check("t1_done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) begin
      check("t1_done_cycle", dn_cyc[0], t0 + 13);
      check("t1_done_tag", dn_tag[0], 3);
      check("t1_done_err", dn_err[0], 0);
    end
    check("t1_idle", bus.idle, 1);

    // Illegal opcode is rejected without an engine pulse.
    clear_ev();
    push(8'h05, 4'd0, 48'h0ABC, 4'd7, t0, acc);
    tick(5);
    check("t2a_issue_count", iss_cyc.size(), 0);
    check("t2a_done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) begin
      check("t2a_done_cycle", dn_cyc[0], t0 + 2);
      check("t2a_done_tag", dn_tag[0], 7);
      check("t2a_done_err", dn_err[0], 1);
    end

    // Legal opcode with an out-of-range slot is rejected the same way.
    clear_ev();
    push(OPC_LOAD, 4'd5, 48'h0DEF, 4'hA, t0, acc);
    tick(5);
    check("t2b_issue_count", iss_cyc.size(), 0);
    check("t2b_done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) begin
      check("t2b_done_cycle", dn_cyc[0], t0 + 2);
      check("t2b_done_tag", dn_tag[0], 4'hA);
      check("t2b_done_err", dn_err[0], 1);
    end
    check("t2_eng_opcode_held", bus.eng_cmd_opcode, 8'h10);
    check("t2_eng_slot_held", bus.eng_cmd_slot, 1);

    // Fill the FIFO while the engine is busy; ninth push is refused.
    clear_ev();
    eng_hold = 1'b1;
    tick(1);
    for (int k = 0; k < 9; k++) begin
      push(opc_tab[k % 4], 4'(k % 4), 48'(k) * 48'h1000, 4'(k), t0, acc);
      check($sformatf("t3_accept%0d", k), acc, (k < 8) ? 1 : 0);
    end
    check("t3_full_host_ready", bus.host_ready, 0);
    check("t3_full_count", bus.fifo_count, 8);
    check("t3_full_idle", bus.idle, 0);
    busy_len = 2;
    eng_hold = 1'b0;
    tick(60);
    check("t3_issue_count", iss_cyc.size(), 8);
    check("t3_done_count", dn_cyc.size(), 8);
    if (iss_cyc.size() == 8 && dn_cyc.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("t3_done_tag%0d", k), dn_tag[k], k);
        check($sformatf("t3_done_err%0d", k), dn_err[k], 0);
        check($sformatf("t3_issue_op%0d", k), iss_op[k], opc_tab[k % 4]);
        check($sformatf("t3_issue_slot%0d", k), iss_slot[k], k % 4);
      end
      check("t3_back_to_back", iss_cyc[1], dn_cyc[0] + 2);
    end
    check("t3_drained_count", bus.fifo_count, 0);
    check("t3_drained_idle", bus.idle, 1);

    // Head waits for engine ready, then issues promptly.
    clear_ev();
    busy_len = 3;
    eng_hold = 1'b1;
    tick(1);
    push(OPC_STORE, 4'd3, 48'h0000_0000_FEED, 4'd5, t0, acc);
    tick(6);
    check("t4_no_issue", iss_cyc.size(), 0);
    check("t4_held_count", bus.fifo_count, 1);
    r = cyc;
    eng_hold = 1'b0;
    tick(15);
    check("t4_issue_count", iss_cyc.size(), 1);
    if (iss_cyc.size() > 0) check("t4_issue_within_2", (iss_cyc[0] - r) <= 2, 1);
    check("t4_done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) check("t4_done_tag", dn_tag[0], 5);

    // Reset while waiting on the engine with three commands queued.
    clear_ev();
    busy_len = 30;
    push(OPC_NTT, 4'd0, 48'h0, 4'd1, t0, acc);
    push(OPC_INTT, 4'd2, 48'h10, 4'd2, t0, acc);
    check("t5_push_pop_same_cycle", bus.fifo_count, 1);
    push(OPC_LOAD, 4'd1, 48'h20, 4'd3, t0, acc);
    push(OPC_STORE, 4'd2, 48'h30, 4'd4, t0, acc);
    tick(4);
    check("t5_pre_count", bus.fifo_count, 3);
    check("t5_pre_issued", iss_cyc.size(), 1);
    check("t5_pre_idle", bus.idle, 0);
    clear_ev();
    rst = 1'b1;
    tick(1);
    check("t5_rst_count", bus.fifo_count, 0);
    check("t5_rst_idle", bus.idle, 1);
    check("t5_rst_eng_valid", bus.eng_cmd_valid, 0);
    check("t5_rst_done_valid", bus.done_valid, 0);
    check("t5_rst_host_ready", bus.host_ready, 1);
    rst = 1'b0;
    tick(40);
    check("t5_no_done_after", dn_cyc.size(), 0);
    check("t5_no_issue_after", iss_cyc.size(), 0);

    // Two legal commands and one rejected; 4 + 1 + 4 non-idle cycles with busy_len 3.
    clear_ev();
    busy_len = 3;
    push(OPC_NTT, 4'd1, 48'h100, 4'd1, t0, acc);
    tick(8);
    push(8'h7F, 4'd0, 48'h200, 4'd2, t0, acc);
    tick(4);
    push(OPC_INTT, 4'd3, 48'h300, 4'd3, t0, acc);
    tick(10);
    check("t6_done_count", dn_cyc.size(), 3);
    if (dn_cyc.size() == 3) begin
      check("t6_err0", dn_err[0], 0);
      check("t6_err1", dn_err[1], 1);
      check("t6_err2", dn_err[2], 0);
    end
`ifdef NTT_SCHED_PERF_EN
    check("t6_perf_cmds", perf_cmds, 2);
    check("t6_perf_busy", perf_busy, 9);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
